// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter and the matching receiver:
// parity mode codes, the transmit FSM encoding and parameter legality.
package uart_pkg;

  // Parity mode codes for the PARITY parameter
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Transmit FSM states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } tx_state_e;

  // True when a frame configuration can be built; evaluated at elaboration
  function automatic bit params_legal(input int clks_per_bit,
                                      input int data_bits,
                                      input int parity,
                                      input int stop_bits);
    return (clks_per_bit >= 2) &&
           (data_bits >= 5) && (data_bits <= 9) &&
           (parity >= PAR_NONE) && (parity <= PAR_EVEN) &&
           ((stop_bits == 1) || (stop_bits == 2));
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Byte-source side of the UART transmitter: valid/ready handshake, data word,
// break request and the line/status outputs.
interface uart_tx_frame_if #(
  parameter int DATA_BITS = 8
);

  logic                 i_Tx_DV;
  logic [DATA_BITS-1:0] i_Tx_Data;
  logic                 i_Tx_Break;
  logic                 o_Tx_Ready;
  logic                 o_Tx_Active;
  logic                 o_Tx_Serial;
  logic                 o_Tx_Done;

  // Byte source (FIFO or controller) view
  modport master (
    output i_Tx_DV, i_Tx_Data, i_Tx_Break,
    input  o_Tx_Ready, o_Tx_Active, o_Tx_Serial, o_Tx_Done
  );

  // Transmitter view
  modport slave (
    input  i_Tx_DV, i_Tx_Data, i_Tx_Break,
    output o_Tx_Ready, o_Tx_Active, o_Tx_Serial, o_Tx_Done
  );

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period timer shared by the UART transmitter and receiver. While restart
// is high the counter is held at its reload value; once released it counts
// down and strobes bit_end for one cycle every CLKS_PER_BIT cycles.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic restart,
  output logic bit_end
);

  localparam int            CW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  // Down-counter, reloaded on restart and at every bit boundary
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    // NOTE: state registers use <= so every flop samples pre-edge values;
    // a blocking = here would let later statements see the updated count.
    if (i_Reset) begin
      count <= '0;
    end else if (restart || (count == '0)) begin
      count <= RELOAD;
    end else begin
      count <= count - CW'(1);
    end
  end

  // Strobe in the last cycle of each bit period; the next edge is the boundary
  assign bit_end = !restart && (count == '0);

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: one word per frame, LSB first, with optional
// odd/even parity, 1 or 2 stop bits, valid/ready handshake and line break.
// The start bit is driven from the acceptance edge; Done pulses for one cycle
// at the edge that ends the last stop bit.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PAR_NONE,
  parameter int STOP_BITS    = 1
) (
  input logic           i_Clock,
  input logic           i_Reset,
  uart_tx_frame_if.slave tx
);

  localparam int               IDX_W     = $clog2(DATA_BITS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = (STOP_BITS == 2);
  localparam logic             ODD_MODE  = (PARITY == PAR_ODD);
  localparam bit               HAS_PAR   = (PARITY != PAR_NONE);

  // Refuse to elaborate an impossible frame configuration
  if (!params_legal(CLKS_PER_BIT, DATA_BITS, PARITY, STOP_BITS)) begin : g_illegal_params
    $fatal(1, "uart_tx_frame: illegal CLKS_PER_BIT/DATA_BITS/PARITY/STOP_BITS");
  end

  tx_state_e            state;
  logic [DATA_BITS-1:0] shift_reg;
  logic [IDX_W-1:0]     bit_idx;
  logic                 stop_cnt;
  logic                 parity_bit;
  logic                 serial_q;
  logic                 active_q;
  logic                 done_q;
  logic                 restart;
  logic                 bit_end;

  // The timer idles at its reload value so the first bit lasts a full period
  // counted from the acceptance edge.
  assign restart = (state == ST_IDLE) || (state == ST_BREAK);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .restart (restart),
    .bit_end (bit_end)
  );

  // Frame sequencer with registered line and status outputs
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state      <= ST_IDLE;
      // NOTE: the data shift register is reset along with the control state;
      // it lives in the same async-reset block, and leaving it out would turn
      // reset into an extra load-enable term on every data flop.
      shift_reg  <= '0;
      bit_idx    <= '0;
      stop_cnt   <= 1'b0;
      parity_bit <= 1'b0;
      serial_q   <= 1'b1;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tx.i_Tx_Break) begin
            state    <= ST_BREAK;
            serial_q <= 1'b0;
          end else if (tx.i_Tx_DV) begin
            shift_reg <= tx.i_Tx_Data;
            state     <= ST_START;
            serial_q  <= 1'b0;
            active_q  <= 1'b1;
          end
        end

        ST_START: begin
          if (bit_end) begin
            // Parity comes from the latched word, still complete at this point
            parity_bit <= (^shift_reg) ^ ODD_MODE;
            serial_q   <= shift_reg[0];
            shift_reg  <= shift_reg >> 1;
            bit_idx    <= '0;
            state      <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (bit_end) begin
            if (bit_idx == LAST_IDX) begin
              if (HAS_PAR) begin
                state    <= ST_PARITY;
                serial_q <= parity_bit;
              end else begin
                state    <= ST_STOP;
                serial_q <= 1'b1;
                stop_cnt <= 1'b0;
              end
            end else begin
              serial_q  <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
              bit_idx   <= bit_idx + IDX_W'(1);
            end
          end
        end

        ST_PARITY: begin
          if (bit_end) begin
            state    <= ST_STOP;
            serial_q <= 1'b1;
            stop_cnt <= 1'b0;
          end
        end

        ST_STOP: begin
          if (bit_end) begin
            if (stop_cnt == STOP_LAST) begin
              state    <= ST_IDLE;
              active_q <= 1'b0;
              done_q   <= 1'b1;
              serial_q <= 1'b1;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end

        ST_BREAK: begin
          if (!tx.i_Tx_Break) begin
            state    <= ST_IDLE;
            serial_q <= 1'b1;
          end
        end

        default: begin
          state    <= ST_IDLE;
          serial_q <= 1'b1;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  // Ready is combinational so a break request blocks acceptance in the same cycle
  assign tx.o_Tx_Ready  = (state == ST_IDLE) && !tx.i_Tx_Break;
  assign tx.o_Tx_Active = active_q;
  assign tx.o_Tx_Serial = serial_q;
  assign tx.o_Tx_Done   = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: 8N1, 7E2 and 7O2 instances at four clocks
// per bit, with hand-computed frame bit patterns (bit k of the constant is
// frame bit k, start bit first).
module tb_uart_tx_frame;
  import uart_pkg::*;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dv;
  logic [2:0] brk;
  logic [7:0] data;

  int checks = 0;
  int errors = 0;
  int sel    = 0;

  always #5 clk = ~clk;

  uart_tx_frame_if #(.DATA_BITS(8)) if_a ();
  uart_tx_frame_if #(.DATA_BITS(7)) if_b ();
  uart_tx_frame_if #(.DATA_BITS(7)) if_c ();

  assign if_a.i_Tx_DV    = dv[0];
  assign if_a.i_Tx_Data  = data;
  assign if_a.i_Tx_Break = brk[0];
  assign if_b.i_Tx_DV    = dv[1];
  assign if_b.i_Tx_Data  = data[6:0];
  assign if_b.i_Tx_Break = brk[1];
  assign if_c.i_Tx_DV    = dv[2];
  assign if_c.i_Tx_Data  = data[6:0];
  assign if_c.i_Tx_Break = brk[2];

  uart_tx_frame #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1))
    dut_a (.i_Clock(clk), .i_Reset(rst), .tx(if_a.slave));
  uart_tx_frame #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY(PAR_EVEN), .STOP_BITS(2))
    dut_b (.i_Clock(clk), .i_Reset(rst), .tx(if_b.slave));
  uart_tx_frame #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY(PAR_ODD), .STOP_BITS(2))
    dut_c (.i_Clock(clk), .i_Reset(rst), .tx(if_c.slave));

  logic obs_serial, obs_active, obs_done, obs_ready;

  // Route the selected instance's outputs to the observation signals
  always_comb begin
    // NOTE: every output gets a default before the case so no latch is implied.
    obs_serial = if_a.o_Tx_Serial;
    obs_active = if_a.o_Tx_Active;
    obs_done   = if_a.o_Tx_Done;
    obs_ready  = if_a.o_Tx_Ready;
    case (sel)
      1: begin
        obs_serial = if_b.o_Tx_Serial;
        obs_active = if_b.o_Tx_Active;
        obs_done   = if_b.o_Tx_Done;
        obs_ready  = if_b.o_Tx_Ready;
      end
      2: begin
        obs_serial = if_c.o_Tx_Serial;
        obs_active = if_c.o_Tx_Active;
        obs_done   = if_c.o_Tx_Done;
        obs_ready  = if_c.o_Tx_Ready;
      end
      default: ;
    endcase
  end

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after edge 0 of a frame; checks every cycle through edge F*C
  task automatic expect_frame(input string name, input logic [15:0] bits, input int nbits);
    logic [3:0] exp_v;
    logic [3:0] got_v;
    for (int e = 0; e < nbits * C; e++) begin
      if (e > 0) tick();
      exp_v = {bits[e / C], 1'b1, 1'b0, 1'b0};
      got_v = {obs_serial, obs_active, obs_done, obs_ready};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL %s edge %0d {serial,active,done,ready}: got %b expected %b",
                 name, e, got_v, exp_v);
      end
    end
    tick();
    exp_v = {1'b1, 1'b0, 1'b1, ~brk[sel]};
    got_v = {obs_serial, obs_active, obs_done, obs_ready};
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL %s frame end edge %0d {serial,active,done,ready}: got %b expected %b",
               name, nbits * C, got_v, exp_v);
    end
  endtask

  // Send one word on instance s, check the frame and the idle cycle after Done
  task automatic test_frame(input string name, input int s, input logic [7:0] word,
                            input logic [15:0] bits, input int nbits);
    sel   = s;
    data  = word;
    dv[s] = 1'b1;
    tick();
    dv[s] = 1'b0;
    expect_frame(name, bits, nbits);
    tick();
    checks++;
    if ({obs_serial, obs_active, obs_done, obs_ready} !== 4'b1001) begin
      errors++;
      $display("FAIL %s after done {serial,active,done,ready}: got %b expected 1001",
               name, {obs_serial, obs_active, obs_done, obs_ready});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #0;
      checks++;
      if ({obs_serial, obs_active, obs_done, obs_ready} !== 4'b1001) begin
        errors++;
        $display("FAIL reset inst %0d {serial,active,done,ready}: got %b expected 1001",
                 s, {obs_serial, obs_active, obs_done, obs_ready});
      end
    end
    rst = 1'b0;
    sel = 0;
    tick();
    checks++;
    if ({obs_serial, obs_active, obs_done, obs_ready} !== 4'b1001) begin
      errors++;
      $display("FAIL reset release {serial,active,done,ready}: got %b expected 1001",
               {obs_serial, obs_active, obs_done, obs_ready});
    end
  endtask

  task automatic test_8n1();
    test_frame("8n1_a5", 0, 8'hA5, 16'h034A, 10);
  endtask

  task automatic test_parity();
    test_frame("7e2_13", 1, 8'h13, 16'h0726, 11);
    test_frame("7o2_13", 2, 8'h13, 16'h0626, 11);
  endtask

  // DV held high across two frames; data changes mid-frame must not leak in
  task automatic test_back_to_back();
    sel   = 0;
    data  = 8'h01;
    dv[0] = 1'b1;
    tick();
    data = 8'h80;
    expect_frame("b2b_01", 16'h0202, 10);
    tick();
    dv[0] = 1'b0;
    expect_frame("b2b_80", 16'h0300, 10);
    tick();
    checks++;
    if ({obs_serial, obs_active, obs_done, obs_ready} !== 4'b1001) begin
      errors++;
      $display("FAIL b2b after done {serial,active,done,ready}: got %b expected 1001",
               {obs_serial, obs_active, obs_done, obs_ready});
    end
  endtask

  task automatic test_reset_mid_frame();
    sel   = 0;
    data  = 8'h00;
    dv[0] = 1'b1;
    tick();
    dv[0] = 1'b0;
    repeat (17) tick();
    checks++;
    if ({obs_serial, obs_active} !== 2'b01) begin
      errors++;
      $display("FAIL rst_mid data bit 3 {serial,active}: got %b expected 01",
               {obs_serial, obs_active});
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({obs_serial, obs_active, obs_done, obs_ready} !== 4'b1001) begin
      errors++;
      $display("FAIL rst_mid async {serial,active,done,ready}: got %b expected 1001",
               {obs_serial, obs_active, obs_done, obs_ready});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs_done !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid done during reset cycle %0d: got %b expected 0", i, obs_done);
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({obs_serial, obs_active, obs_done, obs_ready} !== 4'b1001) begin
      errors++;
      $display("FAIL rst_mid released {serial,active,done,ready}: got %b expected 1001",
               {obs_serial, obs_active, obs_done, obs_ready});
    end
    test_frame("rst_5a", 0, 8'h5A, 16'h02B4, 10);
  endtask

  // Break and DV together in IDLE: break wins, then DV is taken after release
  task automatic test_break_idle();
    sel    = 0;
    data   = 8'hA5;
    dv[0]  = 1'b1;
    brk[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if ({obs_serial, obs_active, obs_done, obs_ready} !== 4'b0000) begin
        errors++;
        $display("FAIL brk_idle held cycle %0d {serial,active,done,ready}: got %b expected 0000",
                 i, {obs_serial, obs_active, obs_done, obs_ready});
      end
    end
    brk[0] = 1'b0;
    #1;
    checks++;
    if ({obs_serial, obs_ready} !== 2'b00) begin
      errors++;
      $display("FAIL brk_idle before edge {serial,ready}: got %b expected 00",
               {obs_serial, obs_ready});
    end
    tick();
    checks++;
    if ({obs_serial, obs_active, obs_done, obs_ready} !== 4'b1001) begin
      errors++;
      $display("FAIL brk_idle release {serial,active,done,ready}: got %b expected 1001",
               {obs_serial, obs_active, obs_done, obs_ready});
    end
    tick();
    dv[0] = 1'b0;
    expect_frame("brk_idle_a5", 16'h034A, 10);
    tick();
    checks++;
    if ({obs_serial, obs_active, obs_done, obs_ready} !== 4'b1001) begin
      errors++;
      $display("FAIL brk_idle after done {serial,active,done,ready}: got %b expected 1001",
               {obs_serial, obs_active, obs_done, obs_ready});
    end
  endtask

  // Break raised right after acceptance waits for the frame to finish
  task automatic test_break_mid_frame();
    sel   = 0;
    data  = 8'hA5;
    dv[0] = 1'b1;
    tick();
    dv[0]  = 1'b0;
    brk[0] = 1'b1;
    expect_frame("brk_mid_a5", 16'h034A, 10);
    tick();
    checks++;
    if ({obs_serial, obs_active, obs_done, obs_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL brk_mid after done {serial,active,done,ready}: got %b expected 0000",
               {obs_serial, obs_active, obs_done, obs_ready});
    end
    brk[0] = 1'b0;
    tick();
    checks++;
    if ({obs_serial, obs_active, obs_done, obs_ready} !== 4'b1001) begin
      errors++;
      $display("FAIL brk_mid release {serial,active,done,ready}: got %b expected 1001",
               {obs_serial, obs_active, obs_done, obs_ready});
    end
  endtask

  initial begin
    rst  = 1'b1;
    dv   = '0;
    brk  = '0;
    data = '0;
    test_reset();
    test_8n1();
    test_parity();
    test_back_to_back();
    test_reset_mid_frame();
    test_break_idle();
    test_break_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter that serialises one data word per frame, LSB first. Frame format is configurable at elaboration:
- 5–9 data bits
- optional odd or even parity
- 1 or 2 stop bits

It adds a valid/ready handshake, asynchronous reset and a line-break request. It sits between a byte source (FIFO or controller FSM) and the TX pin, and replaces the fixed 8N1 transmitter in new designs.

## Interface
- CLKS_PER_BIT, 87, i_Clock cycles per bit; legal range ≥ 2.
- DATA_BITS, 8, data bits per frame; legal range 5–9.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
- i_Clock  in  1  Single clock. All logic is on the rising edge.
- i_Reset  in  1  Asynchronous, active-high reset.
- i_Tx_DV  in  1  Data valid. Sampled only when o_Tx_Ready = 1.
- i_Tx_Data  in  DATA_BITS  Word to transmit. Latched on acceptance.
- i_Tx_Break  in  1  Break request: while high and not mid-frame, drive the line low.
- o_Tx_Ready  out  1  Block is idle and can accept a word.
- o_Tx_Active  out  1  A frame is in progress.
- o_Tx_Serial  out  1  TX line. Registered output. Idle level is 1.
- o_Tx_Done  out  1  One-cycle pulse at frame end.

## Operation
- Frame length: F = 1 + DATA_BITS + (PARITY ≠ 0) + STOP_BITS bits. Each bit lasts exactly CLKS_PER_BIT cycles.
- States and transitions:
  - IDLE: on DV → START; on Break → BREAK.
  - START → DATA.
  - DATA → PARITY, or DATA → STOP when PARITY = 0.
  - PARITY → STOP.
  - STOP → IDLE.
  - BREAK → IDLE when i_Tx_Break falls.
- Bit timer: down-counter of width $clog2(CLKS_PER_BIT), reloaded at each bit boundary. Bit index counter width is $clog2(DATA_BITS+1). The stop-bit counter counts STOP_BITS.
- Data shift: the word is latched into a shift register on acceptance and shifted right, one bit per bit period.
- Parity bit:
  - Even: XOR of the latched data.
  - Odd: the inverse of that XOR.
  - Parity is computed from the latched word, never from live i_Tx_Data.
- o_Tx_Ready = (state == IDLE) && !i_Tx_Break. This is combinational from the state and i_Tx_Break.
- Inputs while not ready:
  - i_Tx_DV is ignored whenever o_Tx_Ready = 0.
  - i_Tx_Data changes during a frame have no effect.
- Break priority:
  - If i_Tx_DV and i_Tx_Break are both high in IDLE, break wins and the word is not accepted.
  - Break raised mid-frame is ignored until the frame completes.
- Reset values: o_Tx_Serial = 1, o_Tx_Active = 0, o_Tx_Done = 0, o_Tx_Ready = 1 (with i_Tx_Break low), state = IDLE, all counters 0.
- Reset mid-frame: outputs go to their reset values immediately (asynchronously). The frame is abandoned and no Done pulse is issued.

## Timing
- Acceptance: word accepted at rising edge N (IDLE, DV = 1, Break = 0).
  - From edge N, o_Tx_Serial = 0 and o_Tx_Active = 1.
  - Zero-cycle latency from acceptance to start bit.
- Bit k of the frame (start bit is k = 0) occupies edges N + k·C through N + (k+1)·C − 1, where C = CLKS_PER_BIT.
- Frame end, at edge N + F·C:
  - State returns to IDLE, o_Tx_Active = 0, o_Tx_Done = 1, o_Tx_Serial = 1.
  - o_Tx_Done clears at the next edge.
- Back-to-back frames:
  - A DV held high during the Done cycle is accepted at edge N + F·C + 1.
  - Minimum frame period is therefore F·C + 1 cycles; the extra cycle lengthens the stop level by one clock.
- Break timing:
  - Line low from the edge at which BREAK is entered.
  - Line high from the edge after i_Tx_Break is sampled low.
  - No Done pulse is issued for a break.

## Structure
- Shared package uart_pkg holds:
  - Parity mode constants PAR_NONE = 0, PAR_ODD = 1, PAR_EVEN = 2.
  - The FSM state encoding.
  - Legal-range checks as elaboration assertions. Illegal DATA_BITS, STOP_BITS, PARITY or CLKS_PER_BIT values abort elaboration.
- One sub-module, uart_bit_timer:
  - Parametrised on CLKS_PER_BIT.
  - Inputs: clock, reset, restart.
  - Output: a one-cycle bit_end strobe.
  - Intended for reuse by the matching receiver.

## Test plan
- 8N1, C = 4, word 0xA5 accepted at edge 0:
  - Serial levels per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1.
  - o_Tx_Done high only in the cycle after edge 40.
  - Active high for edges 0–39.
- 7E2 (DATA_BITS = 7, PARITY = 2, STOP_BITS = 2), C = 4, word 0x13 (three ones):
  - Parity bit = 1.
  - Line high for 8 cycles after the parity bit.
  - Done after edge 44.
  - Repeating with PARITY = 1 gives parity bit = 0.
- DV held high continuously with words 0x01 then 0x80 (8N1, C = 4):
  - Second start bit begins exactly 41 cycles after the first.
  - Any DV presented while Active is ignored.
- Reset asserted mid-frame, during data bit 3:
  - Serial = 1 and Active = 0 without waiting for a clock edge.
  - No Done pulse.
  - After release, a new word 0x5A transmits correctly.
- Break raised in IDLE together with DV:
  - Line low and Ready = 0 while break is held; the word is not sent.
  - Line returns high one edge after break falls, then DV is accepted normally.
- Break raised mid-frame:
  - The frame completes unaltered with its Done pulse.
  - Line goes low on the edge after Done.
